// File: rtl/tdm_mux_scanner.sv
// Registered N-channel TDM multiplexer with a manual select mode and a masked
// auto-scan mode that dwells DWELL cycles per enabled channel.
module tdm_mux_scanner #(
  parameter int N_CH   = 8,
  parameter int DATA_W = 1,
  parameter int SEL_W  = 3,
  parameter int DWELL  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH*DATA_W-1:0]   din,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [N_CH-1:0]          ch_en,
  output logic [DATA_W-1:0]        dout,
  output logic [SEL_W-1:0]         ch_idx,
  output logic                     dout_valid,
  output logic                     frame_done
);

  localparam int CNT_W = $clog2(DWELL) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t              state_p1, state_nxt;
  logic [CNT_W-1:0]    cnt_p1, cnt_nxt;
  logic [DATA_W-1:0]   dout_p1, dout_nxt;
  logic [SEL_W-1:0]    ch_idx_p1, ch_idx_nxt;
  logic                vld_p1, vld_nxt;
  logic                fd_p1, fd_nxt;

  logic                any_en;
  logic                sel_ok;
  logic                scan_adv;
  logic [SEL_W-1:0]    low_ch;
  logic [SEL_W-1:0]    nxt_ch;

  function automatic logic [SEL_W-1:0] lowest_en(input logic [N_CH-1:0] en);
    lowest_en = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (en[i]) lowest_en = SEL_W'(i);
  endfunction

  // Smallest enabled index strictly above cur, else wrap to the lowest enabled.
  function automatic logic [SEL_W-1:0] next_en(input logic [N_CH-1:0] en,
                                               input logic [SEL_W-1:0] cur);
    next_en = lowest_en(en);
    for (int i = N_CH - 1; i >= 0; i--)
      if (en[i] && (i > int'(cur))) next_en = SEL_W'(i);
  endfunction

  function automatic logic [DATA_W-1:0] pick(input logic [N_CH*DATA_W-1:0] d,
                                             input logic [SEL_W-1:0] idx);
    pick = '0;
    for (int i = 0; i < N_CH; i++)
      if (SEL_W'(i) == idx) pick = d[i*DATA_W +: DATA_W];
  endfunction

  // Stage p1: every output comes straight from this register set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1  <= IDLE;
      cnt_p1    <= '0;
      dout_p1   <= '0;
      ch_idx_p1 <= '0;
      vld_p1    <= 1'b0;
      fd_p1     <= 1'b0;
    end else begin
      state_p1  <= state_nxt;
      cnt_p1    <= cnt_nxt;
      dout_p1   <= dout_nxt;
      ch_idx_p1 <= ch_idx_nxt;
      vld_p1    <= vld_nxt;
      fd_p1     <= fd_nxt;
    end
  end

  always_comb begin
    state_nxt = state_p1;
    if (!mode)
      state_nxt = MANUAL;
    else if (ch_en == '0)
      state_nxt = IDLE;
    else
      state_nxt = SCAN;
  end

  always_comb begin
    any_en     = |ch_en;
    sel_ok     = (32'(sel) < 32'(N_CH));
    scan_adv   = !ch_en[ch_idx_p1] || (cnt_p1 == CNT_LAST);
    low_ch     = lowest_en(ch_en);
    nxt_ch     = next_en(ch_en, ch_idx_p1);
    dout_nxt   = '0;
    ch_idx_nxt = ch_idx_p1;
    vld_nxt    = 1'b0;
    fd_nxt     = 1'b0;
    cnt_nxt    = '0;
    if (!mode) begin
      ch_idx_nxt = sel;
      if (sel_ok) begin
        dout_nxt = pick(din, sel);
        vld_nxt  = 1'b1;
      end
    end else if (!any_en) begin
      // Nothing to scan: output idles invalid, ch_idx keeps its last value.
      vld_nxt = 1'b0;
    end else if (state_p1 != SCAN) begin
      ch_idx_nxt = low_ch;
      dout_nxt   = pick(din, low_ch);
      vld_nxt    = 1'b1;
    end else if (scan_adv) begin
      ch_idx_nxt = nxt_ch;
      dout_nxt   = pick(din, nxt_ch);
      vld_nxt    = 1'b1;
      fd_nxt     = (nxt_ch <= ch_idx_p1);
    end else begin
      cnt_nxt  = cnt_p1 + CNT_W'(1);
      dout_nxt = pick(din, ch_idx_p1);
      vld_nxt  = 1'b1;
    end
  end

  assign dout       = dout_p1;
  assign ch_idx     = ch_idx_p1;
  assign dout_valid = vld_p1;
  assign frame_done = fd_p1;

endmodule

// File: tb/tb_tdm_mux_scanner.sv
// Scoreboard bench for tdm_mux_scanner: an 8-channel DWELL=2 instance and a
// 4-channel DWELL=1 instance, driven by directed vectors.
module tb_tdm_mux_scanner;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0_n, mode0;
  logic [2:0] sel0;
  logic [7:0] en0, din0;
  logic [0:0] dout0;
  logic [2:0] idx0;
  logic       vld0, fd0;

  logic       rst1_n, mode1;
  logic [1:0] sel1;
  logic [3:0] en1, din1;
  logic [0:0] dout1;
  logic [1:0] idx1;
  logic       vld1, fd1;

  tdm_mux_scanner #(.N_CH(8), .DATA_W(1), .SEL_W(3), .DWELL(2)) dut0 (
    .clk(clk), .rst_n(rst0_n), .din(din0), .mode(mode0), .sel(sel0),
    .ch_en(en0), .dout(dout0), .ch_idx(idx0), .dout_valid(vld0), .frame_done(fd0));

  tdm_mux_scanner #(.N_CH(4), .DATA_W(1), .SEL_W(2), .DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .din(din1), .mode(mode1), .sel(sel1),
    .ch_en(en1), .dout(dout1), .ch_idx(idx1), .dout_valid(vld1), .frame_done(fd1));

  typedef struct {
    string      nm;
    logic [7:0] d;
    logic [7:0] i;
    logic       v;
    logic       f;
    logic [3:0] m;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   n_chk  = 0;
  int   n_pass = 0;

  localparam logic [3:0] ALL = 4'b1111;

  task automatic chk(string nm, string fld, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s: got %0d, expected %0d at %0t", nm, fld, act, exp, $time);
  endtask

  task automatic exp0(string nm, logic [7:0] d, logic [7:0] i, logic v, logic f, logic [3:0] m);
    exp_t e;
    e.nm = nm; e.d = d; e.i = i; e.v = v; e.f = f; e.m = m;
    q0.push_back(e);
  endtask

  task automatic exp1(string nm, logic [7:0] d, logic [7:0] i, logic v, logic f, logic [3:0] m);
    exp_t e;
    e.nm = nm; e.d = d; e.i = i; e.v = v; e.f = f; e.m = m;
    q1.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #4;
  endtask

  // Monitors: one expectation per edge, compared 2 time units after the edge.
  always @(posedge clk) begin
    #2;
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      if (e0.m[3]) chk(e0.nm, "dout", 8'(dout0), e0.d);
      if (e0.m[2]) chk(e0.nm, "ch_idx", 8'(idx0), e0.i);
      if (e0.m[1]) chk(e0.nm, "dout_valid", 8'(vld0), 8'(e0.v));
      if (e0.m[0]) chk(e0.nm, "frame_done", 8'(fd0), 8'(e0.f));
    end
  end

  always @(posedge clk) begin
    #2;
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      if (e1.m[3]) chk(e1.nm, "dout", 8'(dout1), e1.d);
      if (e1.m[2]) chk(e1.nm, "ch_idx", 8'(idx1), e1.i);
      if (e1.m[1]) chk(e1.nm, "dout_valid", 8'(vld1), 8'(e1.v));
      if (e1.m[0]) chk(e1.nm, "frame_done", 8'(fd1), 8'(e1.f));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         sw_exp [8]  = '{0, 0, 0, 0, 1, 0, 1, 1};
    int         t4_idx [14] = '{2, 2, 4, 4, 7, 7, 2, 2, 4, 4, 7, 7, 2, 2};
    int         t4_fd  [14] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    int         rs_idx [10] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5};
    int         r6_idx [6]  = '{0, 1, 1, 2, 2, 3};
    int         d1_exp [4]  = '{0, 1, 1, 0};
    logic [7:0] pat;
    int         idx;

    pat = 8'hA5;
    rst0_n = 1'b0; mode0 = 1'b1; sel0 = '0; en0 = 8'hFF; din0 = 8'hFF;
    rst1_n = 1'b0; mode1 = 1'b0; sel1 = '0; en1 = '0;   din1 = '0;

    for (int k = 0; k < 3; k++) begin
      exp0("reset", 0, 0, 0, 0, ALL);
      tick();
    end

    rst0_n = 1'b1; mode0 = 1'b0; din0 = 8'b1101_0000;
    for (int s = 0; s < 8; s++) begin
      sel0 = 3'(s);
      exp0("manual", 8'(sw_exp[s]), 8'(s), 1, 0, ALL);
      tick();
    end
    din0 = 8'hFF; sel0 = 3'd7;
    exp0("manual_ones", 1, 7, 1, 0, ALL);
    tick();

    mode0 = 1'b1; en0 = 8'hFF; din0 = 8'hA5;
    for (int k = 0; k < 34; k++) begin
      idx = (k / 2) % 8;
      exp0("scan_full", 8'(pat[idx]), 8'(idx), 1, (k > 0) && (k % 16 == 0), ALL);
      tick();
    end

    en0 = 8'b1001_0100;
    for (int k = 0; k < 14; k++) begin
      exp0("scan_mask", 8'(pat[t4_idx[k]]), 8'(t4_idx[k]), 1, t4_fd[k] != 0, ALL);
      tick();
    end

    en0 = 8'b0000_1000;
    for (int k = 0; k < 6; k++) begin
      din0 = (k % 2 == 0) ? 8'h08 : 8'h00;
      exp0("scan_single", 8'(k % 2 == 0), 3, 1, (k == 2) || (k == 4), ALL);
      tick();
    end

    din0 = 8'hA5; en0 = 8'b1001_0100;
    exp0("dis_pre", 0, 4, 1, 0, ALL);
    tick();
    en0 = 8'b1000_0100;
    exp0("dis_skip", 1, 7, 1, 0, ALL);
    tick();
    en0 = 8'h00;
    exp0("dis_none", 0, 0, 0, 0, 4'b1011);
    tick();
    exp0("idle_hold", 0, 7, 0, 0, ALL);
    tick();
    en0 = 8'hFF;
    exp0("restart", 1, 0, 1, 0, ALL);
    tick();
    for (int k = 0; k < 10; k++) begin
      exp0("rescan", 8'(pat[rs_idx[k]]), 8'(rs_idx[k]), 1, 0, ALL);
      tick();
    end

    mode0 = 1'b0; sel0 = 3'd1;
    exp0("to_manual", 0, 1, 1, 0, ALL);
    tick();
    mode0 = 1'b1;
    exp0("to_auto", 1, 0, 1, 0, ALL);
    tick();
    for (int k = 0; k < 6; k++) begin
      exp0("pre_rst", 8'(pat[r6_idx[k]]), 8'(r6_idx[k]), 1, 0, ALL);
      tick();
    end
    rst0_n = 1'b0;
    exp0("mid_rst", 0, 0, 0, 0, ALL);
    tick();
    rst0_n = 1'b1;
    exp0("post_rst", 1, 0, 1, 0, ALL);
    tick();

    exp1("d1_reset", 0, 0, 0, 0, ALL);
    tick();
    rst1_n = 1'b1; mode1 = 1'b1; en1 = 4'hF; din1 = 4'b0110;
    for (int k = 0; k < 9; k++) begin
      exp1("d1_scan", 8'(d1_exp[k % 4]), 8'(k % 4), 1, (k > 0) && (k % 4 == 0), ALL);
      tick();
    end
    mode1 = 1'b0; sel1 = 2'd2;
    exp1("d1_manual", 1, 2, 1, 0, ALL);
    tick();

    tick();
    tick();
    chk("drain", "q0_left", 8'(q0.size()), 0);
    chk("drain", "q1_left", 8'(q1.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
